// File: rtl/dff_skid_slice_pkg.sv
// Shared types for the skid slice: FSM state encoding and default payload width.
package skid_slice_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_MAIN  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    localparam int SkidDefaultWidth = 8;

endpackage

// File: rtl/dff_skid_slice_if.sv
// Valid/ready bundle around the skid slice; slave is the slice's view, master the environment's.
interface dff_skid_slice_if
    import skid_slice_pkg::*;
#(
    parameter int Width = SkidDefaultWidth
);

    logic             in_valid;
    logic             in_ready;
    logic [Width-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [Width-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

endinterface

// File: rtl/dff_skid_slice_reg.sv
// Enabled data register with asynchronous active-low reset to a per-instance value.
module dff_skid_slice_reg
    import skid_slice_pkg::*;
#(
    parameter int               Width  = SkidDefaultWidth,
    parameter logic [Width-1:0] RstVal = '0
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             en,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            q <= RstVal;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_skid_slice.sv
// Two-entry valid/ready slice (main + skid) with both handshake directions decoded from state flops.
// Optional simulation X/stability checks are enabled by defining DFF_SKID_SLICE_XCHECK_EN.
module dff_skid_slice
    import skid_slice_pkg::*;
#(
    parameter int               Width  = SkidDefaultWidth,
    parameter logic [Width-1:0] RstVal = '0
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             flush,
    dff_skid_slice_if.slave  bus
);

    skid_state_e      state;
    skid_state_e      state_next;
    logic             in_fire;
    logic             out_fire;
    logic             main_en;
    logic             skid_en;
    logic             main_from_skid;
    logic [Width-1:0] main_d;
    logic [Width-1:0] main_q;
    logic [Width-1:0] skid_q;

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= SKID_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            SKID_EMPTY: begin
                if (in_fire) begin
                    state_next = SKID_MAIN;
                    main_en    = 1'b1;
                end
            end
            SKID_MAIN: begin
                case ({in_fire, out_fire})
                    2'b11: main_en = 1'b1;
                    2'b10: begin
                        state_next = SKID_FULL;
                        skid_en    = 1'b1;
                    end
                    2'b01: state_next = SKID_EMPTY;
                    default: state_next = SKID_MAIN;
                endcase
            end
            SKID_FULL: begin
                if (out_fire) begin
                    state_next     = SKID_MAIN;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_next = SKID_EMPTY;
        endcase
        // Flush drops occupancy only; suppressing the loads keeps the data regs untouched.
        if (flush) begin
            state_next = SKID_EMPTY;
            main_en    = 1'b0;
            skid_en    = 1'b0;
        end
    end

    assign main_d = main_from_skid ? skid_q : bus.in_data;

    dff_skid_slice_reg #(.Width(Width), .RstVal(RstVal)) main_reg (
        .CLK  (CLK),
        .RSTN (RSTN),
        .en   (main_en),
        .d    (main_d),
        .q    (main_q)
    );

    dff_skid_slice_reg #(.Width(Width), .RstVal(RstVal)) skid_reg (
        .CLK  (CLK),
        .RSTN (RSTN),
        .en   (skid_en),
        .d    (bus.in_data),
        .q    (skid_q)
    );

    assign bus.out_valid = (state != SKID_EMPTY);
    assign bus.in_ready  = (state != SKID_FULL);
    assign bus.out_data  = main_q;

`ifdef DFF_SKID_SLICE_XCHECK_EN
`ifndef SYNTHESIS
    logic             stall_q;
    logic [Width-1:0] stall_data_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            stall_q      <= 1'b0;
            stall_data_q <= RstVal;
        end else begin
            if ($isunknown({bus.in_valid, bus.out_ready, flush})) begin
                $error("dff_skid_slice: X on in_valid/out_ready/flush");
            end
            if (in_fire && $isunknown(bus.in_data)) begin
                $error("dff_skid_slice: X on in_data during in_fire");
            end
            if (stall_q && (bus.out_data !== stall_data_q)) begin
                $error("dff_skid_slice: out_data changed while stalled");
            end
            stall_q      <= bus.out_valid & ~bus.out_ready;
            stall_data_q <= bus.out_data;
        end
    end
`endif
`else
`endif

endmodule

// File: tb/tb_dff_skid_slice.sv
// Directed and randomized self-checking bench for dff_skid_slice against a queue model.
module tb_dff_skid_slice;
    import skid_slice_pkg::*;

    localparam int Width = 8;

    logic CLK = 1'b0;
    logic RSTN;
    logic flush;

    dff_skid_slice_if #(.Width(Width)) bus ();

    dff_skid_slice #(.Width(Width), .RstVal(8'h00)) dut (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .flush (flush),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int testCount = 0;
    int failCount = 0;
    logic [Width-1:0] sbQueue[$];

    task automatic checkOutput(input string tag, input logic [Width-1:0] observed,
                               input logic [Width-1:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [Width-1:0] d,
                                 input logic r, input logic f);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        flush         = f;
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic             v;
        logic             r;
        logic             f;
        logic [Width-1:0] d;
        logic             modelValid;
        logic             modelReady;
        logic             inFire;
        logic             outFire;

        // Reset with upstream already offering data
        RSTN = 1'b1;
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
        #2 RSTN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset_out_valid", 8'(bus.out_valid), 8'h00);
        checkOutput("reset_in_ready", 8'(bus.in_ready), 8'h01);
        checkOutput("reset_out_data", bus.out_data, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        RSTN = 1'b1;
        nextCycle();
        checkOutput("post_reset_out_valid", 8'(bus.out_valid), 8'h00);
        checkOutput("post_reset_in_ready", 8'(bus.in_ready), 8'h01);

        // Streaming 0x01..0x10 with downstream always ready
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
            checkOutput("stream_in_ready", 8'(bus.in_ready), 8'h01);
            nextCycle();
            checkOutput("stream_out_valid", 8'(bus.out_valid), 8'h01);
            checkOutput("stream_out_data", bus.out_data, 8'(i));
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        nextCycle();
        checkOutput("stream_drain", 8'(bus.out_valid), 8'h00);

        // Backpressure fills main then skid
        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
        nextCycle();
        checkOutput("bp_first_data", bus.out_data, 8'hA1);
        checkOutput("bp_first_ready", 8'(bus.in_ready), 8'h01);
        applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0);
        nextCycle();
        checkOutput("bp_full_ready", 8'(bus.in_ready), 8'h00);
        checkOutput("bp_full_data", bus.out_data, 8'hA1);
        applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            checkOutput("stable_data", bus.out_data, 8'hA1);
            checkOutput("stable_valid", 8'(bus.out_valid), 8'h01);
            checkOutput("stable_ready", 8'(bus.in_ready), 8'h00);
        end
        applyStimulus(1'b1, 8'hA3, 1'b1, 1'b0);
        checkOutput("bp_deliver_a1", bus.out_data, 8'hA1);
        nextCycle();
        checkOutput("bp_deliver_a2", bus.out_data, 8'hA2);
        checkOutput("bp_reopen_ready", 8'(bus.in_ready), 8'h01);
        nextCycle();
        checkOutput("bp_deliver_a3", bus.out_data, 8'hA3);
        checkOutput("bp_a3_valid", 8'(bus.out_valid), 8'h01);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        nextCycle();
        checkOutput("bp_drain", 8'(bus.out_valid), 8'h00);

        // Flush while FULL with a new beat offered
        applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 8'hB2, 1'b0, 1'b0);
        nextCycle();
        checkOutput("flush_pre_full", 8'(bus.in_ready), 8'h00);
        applyStimulus(1'b1, 8'hCC, 1'b0, 1'b1);
        nextCycle();
        checkOutput("flush_out_valid", 8'(bus.out_valid), 8'h00);
        checkOutput("flush_in_ready", 8'(bus.in_ready), 8'h01);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        nextCycle();
        checkOutput("flush_nothing_left", 8'(bus.out_valid), 8'h00);
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
        nextCycle();
        checkOutput("flush_55_valid", 8'(bus.out_valid), 8'h01);
        checkOutput("flush_55_data", bus.out_data, 8'h55);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        nextCycle();
        checkOutput("flush_55_alone", 8'(bus.out_valid), 8'h00);

        // Random traffic against a two-deep queue model, with a mid-run async reset
        sbQueue.delete();
        for (int c = 0; c < 10000; c++) begin
            if (c == 5000) begin
                applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
                RSTN = 1'b0;
                #1;
                checkOutput("midrun_reset_valid", 8'(bus.out_valid), 8'h00);
                checkOutput("midrun_reset_ready", 8'(bus.in_ready), 8'h01);
                checkOutput("midrun_reset_data", bus.out_data, 8'h00);
                sbQueue.delete();
                nextCycle();
                RSTN = 1'b1;
            end
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            f = ($urandom_range(0, 63) == 0);
            d = 8'($urandom);
            applyStimulus(v, d, r, f);
            modelValid = (sbQueue.size() > 0);
            modelReady = (sbQueue.size() < 2);
            checkOutput("rand_out_valid", 8'(bus.out_valid), 8'(modelValid));
            checkOutput("rand_in_ready", 8'(bus.in_ready), 8'(modelReady));
            if (modelValid) begin
                checkOutput("rand_out_data", bus.out_data, sbQueue[0]);
            end
            inFire  = v & modelReady;
            outFire = r & modelValid;
            nextCycle();
            if (f) begin
                sbQueue.delete();
            end else begin
                if (outFire) void'(sbQueue.pop_front());
                if (inFire) sbQueue.push_back(d);
            end
        end

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
